// File: rtl/i_fetch_stage.sv
// Instruction-fetch stage: PC, req/ack instruction-memory port and the IF/ID pipeline register.
// Optional perf counters (stall/flush) are built when IF_PERF_CNT_EN is defined.
module i_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PCWrite_wire,
  input  logic        IFIDWrite_wire,
  input  logic        branchTaken,
  input  logic [31:0] add_outWire,
  input  logic        jump_in,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_out,
  output logic [31:0] npc_out,
  output logic        valid_out
`ifdef IF_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_out,
  output logic [CNT_W-1:0] flush_cnt_out
`endif
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] fetch_addr_r;
  logic [31:0] hold_r;
  logic [31:0] instr_r;
  logic [31:0] npc_r;
  logic        valid_r;
  logic        req_r;

  logic        redirect_s;
  logic        advance_s;
  logic        ack_s;
  logic [31:0] target_s;
  logic [31:0] fetch_next_s;

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  // An ack only counts while a request is actually on the port.
  assign redirect_s   = (branchTaken | jump_in) & PCWrite_wire;
  assign advance_s    = PCWrite_wire & IFIDWrite_wire;
  assign ack_s        = imem_ack & req_r;
  assign target_s     = (jump_in ? jump_target : add_outWire) & 32'hFFFF_FFFC;
  assign fetch_next_s = fetch_addr_r + 32'd4;

  assign imem_req        = req_r;
  assign imem_addr       = fetch_addr_r;
  assign instruction_out = instr_r;
  assign npc_out         = npc_r;
  assign valid_out       = valid_r;

  // Fetch FSM together with PC, hold buffer and IF/ID register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r      <= S_REQ;
      pc_r         <= RESET_PC;
      fetch_addr_r <= RESET_PC;
      hold_r       <= 32'h0;
      instr_r      <= 32'h0;
      npc_r        <= 32'h0;
      valid_r      <= 1'b0;
      req_r        <= 1'b0;
    end else begin
      case (state_r)
        S_REQ: begin
          if (redirect_s) begin
            pc_r    <= target_s;
            instr_r <= 32'h0;
            valid_r <= 1'b0;
            req_r   <= 1'b1;
            if (ack_s) fetch_addr_r <= target_s;
            else       state_r      <= S_DROP;
          end else if (ack_s && advance_s) begin
            instr_r      <= imem_rdata;
            npc_r        <= fetch_next_s;
            valid_r      <= 1'b1;
            pc_r         <= fetch_next_s;
            fetch_addr_r <= fetch_next_s;
            req_r        <= 1'b1;
          end else if (ack_s) begin
            hold_r  <= imem_rdata;
            state_r <= S_HOLD;
            req_r   <= 1'b0;
            if (IFIDWrite_wire) begin
              instr_r <= 32'h0;
              valid_r <= 1'b0;
            end
          end else begin
            req_r <= 1'b1;
            if (IFIDWrite_wire) begin
              instr_r <= 32'h0;
              valid_r <= 1'b0;
            end
          end
        end
        S_HOLD: begin
          if (redirect_s) begin
            pc_r         <= target_s;
            fetch_addr_r <= target_s;
            instr_r      <= 32'h0;
            valid_r      <= 1'b0;
            state_r      <= S_REQ;
            req_r        <= 1'b1;
          end else if (advance_s) begin
            instr_r      <= hold_r;
            npc_r        <= fetch_next_s;
            valid_r      <= 1'b1;
            pc_r         <= fetch_next_s;
            fetch_addr_r <= fetch_next_s;
            state_r      <= S_REQ;
            req_r        <= 1'b1;
          end else begin
            req_r <= 1'b0;
            if (IFIDWrite_wire) begin
              instr_r <= 32'h0;
              valid_r <= 1'b0;
            end
          end
        end
        S_DROP: begin
          // The stale request must complete before the new PC can be presented.
          req_r <= 1'b1;
          if (redirect_s) pc_r <= target_s;
          if (ack_s) begin
            fetch_addr_r <= redirect_s ? target_s : pc_r;
            state_r      <= S_REQ;
          end
          if (redirect_s || IFIDWrite_wire) begin
            instr_r <= 32'h0;
            valid_r <= 1'b0;
          end
        end
        default: begin
          state_r <= S_REQ;
          req_r   <= 1'b1;
          instr_r <= 32'h0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  // Saturating stall and flush counters.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (!advance_s && (stall_cnt_r != {CNT_W{1'b1}}))
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      if (redirect_s && (flush_cnt_r != {CNT_W{1'b1}}))
        flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt_out = stall_cnt_r;
  assign flush_cnt_out = flush_cnt_r;
`endif

endmodule
